// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI write slave:
//   - default width constants for the slave parameters
//   - burst-type encodings (FIXED / INCR / WRAP / reserved)
//   - write-response encodings (OKAY / SLVERR / DECERR)
//   - write-channel FSM state enum
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/axi_slave_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_slave_wr_addr_gen
// Combinational next-beat address for an AXI burst.
// Ports:
//   addr_i      current beat byte address
//   size_i      beat size (bytes = 1 << size_i)
//   len_i       burst length minus one
//   burst_i     burst type (FIXED / INCR / WRAP / reserved)
//   next_addr_o byte address of the following beat
// ---------------------------------------------------------------------------
module axi_slave_wr_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS
) (
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [SIZE_BITS-1:0] size_i,
    input  logic [LEN_BITS-1:0]  len_i,
    input  logic [1:0]           burst_i,
    output logic [ADDR_BITS-1:0] next_addr_o
);

    logic [ADDR_BITS-1:0] incr;
    logic [ADDR_BITS-1:0] incr_addr;
    logic [ADDR_BITS-1:0] wrap_mask;

    assign incr      = ADDR_BITS'(1) << size_i;
    assign incr_addr = addr_i + incr;
    // WRAP window is (len+1)<<size bytes; legal lengths make this a power of two,
    // so the window offset is just the low bits under this mask.
    assign wrap_mask = ((ADDR_BITS'(len_i) + ADDR_BITS'(1)) << size_i) - ADDR_BITS'(1);

    always_comb begin
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_slave_wr.sv
// ---------------------------------------------------------------------------
// axi_slave_wr
// AXI write-channel slave backed by an internal word memory.
// FSM IDLE -> DATA -> RESP -> IDLE with registered ready/valid outputs.
// Ports:
//   aclk, areset_n            clock, synchronous active-low reset
//   aw_*                      write-address channel (aw_cache ignored)
//   w_*                       write-data channel
//   b_*                       write-response channel
//   dbg_addr / dbg_rdata      combinational word read of the memory
// Build option:
//   AXI_SLAVE_WR_STRB_EN      when defined, only strobed bytes are written;
//                             otherwise w_strb is ignored and full words land.
// Errors: SLVERR for protocol/alignment problems (reserved burst, oversize,
// unaligned or reserved-type bursts also suppress all writes), DECERR for
// beats outside the memory (only that beat is dropped). DECERR wins.
// ---------------------------------------------------------------------------
module axi_slave_wr
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS,
    parameter int MEM_DEPTH = AXI_MEM_DEPTH
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic [ADDR_BITS-1:0]         aw_addr,
    input  logic [LEN_BITS-1:0]          aw_len,
    input  logic [SIZE_BITS-1:0]         aw_size,
    input  logic [1:0]                   aw_burst,
    input  logic [3:0]                   aw_cache,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [DATA_BITS-1:0]         w_data,
    input  logic [DATA_BITS/8-1:0]       w_strb,
    input  logic                         w_last,
    input  logic                         w_valid,
    output logic                         w_ready,
    output logic [1:0]                   b_resp,
    output logic                         b_valid,
    input  logic                         b_ready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_BITS-1:0]         dbg_rdata
);

    localparam int STRB_BITS  = DATA_BITS / 8;
    localparam int WORD_SHIFT = $clog2(STRB_BITS);
    localparam int IDX_W      = $clog2(MEM_DEPTH);

    state_e               state_q;
    logic                 aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]           b_resp_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  len_q, cnt_q;
    logic [SIZE_BITS-1:0] size_q;
    logic [1:0]           burst_q;
    logic                 slverr_q, decerr_q, inhibit_q;

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

`ifdef AXI_SLAVE_WR_STRB_EN
    wire unused_in = ^aw_cache;
`else
    wire unused_in = ^{aw_cache, w_strb};
`endif

    // Address-phase legality, evaluated on the incoming request.
    logic [ADDR_BITS-1:0] size_mask;
    logic aw_bad_burst, aw_bad_size, aw_unaligned, aw_bad_wrap, aw_inhibit, aw_slverr;

    assign size_mask    = (ADDR_BITS'(1) << aw_size) - ADDR_BITS'(1);
    assign aw_bad_burst = (aw_burst == BURST_RSVD);
    assign aw_bad_size  = (aw_size > SIZE_BITS'(WORD_SHIFT));
    assign aw_unaligned = |(aw_addr & size_mask);
    assign aw_bad_wrap  = (aw_burst == BURST_WRAP) &&
                          !((aw_len == LEN_BITS'(1)) || (aw_len == LEN_BITS'(3)) ||
                            (aw_len == LEN_BITS'(7)) || (aw_len == LEN_BITS'(15)));
    assign aw_inhibit   = aw_bad_burst || aw_bad_size || aw_unaligned;
    assign aw_slverr    = aw_inhibit || aw_bad_wrap;

    // Per-beat evaluation in DATA.
    logic [ADDR_BITS-1:0] next_addr;
    logic [IDX_W-1:0]     widx;
    logic beat, last_beat, beat_decerr, beat_lasterr, mem_we, slverr_n, decerr_n;
    logic [1:0] resp_n;

    axi_slave_wr_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS),
        .SIZE_BITS (SIZE_BITS)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign widx         = addr_q[WORD_SHIFT +: IDX_W];
    assign beat         = (state_q == ST_DATA) && w_valid && w_ready_q;
    assign last_beat    = (cnt_q == len_q);
    assign beat_decerr  = (addr_q >> WORD_SHIFT) >= ADDR_BITS'(MEM_DEPTH);
    assign beat_lasterr = (w_last != last_beat);
    assign mem_we       = areset_n && beat && !inhibit_q && !beat_decerr;
    assign slverr_n     = slverr_q | beat_lasterr;
    assign decerr_n     = decerr_q | beat_decerr;
    assign resp_n       = decerr_n ? RESP_DECERR : (slverr_n ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q    <= ST_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            cnt_q      <= '0;
            slverr_q   <= 1'b0;
            decerr_q   <= 1'b0;
            inhibit_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // aw_ready comes up one cycle after reset release.
                    aw_ready_q <= 1'b1;
                    if (aw_valid && aw_ready_q) begin
                        addr_q     <= aw_addr;
                        len_q      <= aw_len;
                        size_q     <= aw_size;
                        burst_q    <= aw_burst;
                        cnt_q      <= '0;
                        slverr_q   <= aw_slverr;
                        decerr_q   <= 1'b0;
                        inhibit_q  <= aw_inhibit;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        addr_q   <= next_addr;
                        cnt_q    <= cnt_q + LEN_BITS'(1);
                        slverr_q <= slverr_n;
                        decerr_q <= decerr_n;
                        // Termination is by count, not w_last.
                        if (last_beat) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_resp_q  <= resp_n;
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory is deliberately not reset so beats survive an abandoned burst.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
`ifdef AXI_SLAVE_WR_STRB_EN
            for (int i = 0; i < STRB_BITS; i++) begin
                if (w_strb[i]) mem[widx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
`else
            mem[widx] <= w_data;
`endif
        end
    end

    assign aw_ready  = aw_ready_q;
    assign w_ready   = w_ready_q;
    assign b_valid   = b_valid_q;
    assign b_resp    = b_resp_q;
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi_slave_wr.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_wr
// Directed self-checking bench for axi_slave_wr with hand-computed
// expected memory contents and responses.
// ---------------------------------------------------------------------------
module tb_axi_slave_wr;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] beat_data [0:15];
    logic [3:0]  beat_strb [0:15];

    always #5 aclk = ~aclk;

    axi_slave_wr dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .aw_cache  (aw_cache),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string tag);
        dbg_addr = 8'(idx);
        #1;
        check_eq(tag, dbg_rdata, exp);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = base + 32'(i);
            beat_strb[i] = 4'hF;
        end
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit seen = 1'b0;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (aw_ready) seen = 1'b1;
            tick();
        end
        aw_valid = 1'b0;
        check_eq("aw_handshake", 32'(seen), 32'd1);
        check_eq("w_ready_after_aw", 32'(w_ready), 32'd1);
    endtask

    task automatic w_phase(input int len, input int early);
        for (int b = 0; b <= len; b++) begin
            bit seen = 1'b0;
            w_data  = beat_data[b];
            w_strb  = beat_strb[b];
            w_last  = (early < 0) ? (b == len) : (b == early);
            w_valid = 1'b1;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (w_ready) seen = 1'b1;
                tick();
            end
            if (!seen) check_eq("w_beat_timeout", 32'(seen), 32'd1);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] exp_resp, input int hold, input string tag);
        bit seen = 1'b0;
        b_ready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (b_valid) seen = 1'b1;
            else tick();
        end
        check_eq({tag, "_bvalid"}, 32'(seen), 32'd1);
        check_eq({tag, "_bresp"}, 32'(b_resp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_bvalid"}, 32'(b_valid), 32'd1);
            check_eq({tag, "_hold_bresp"}, 32'(b_resp), 32'(exp_resp));
            check_eq({tag, "_hold_awready"}, 32'(aw_ready), 32'd0);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check_eq({tag, "_awready_after_b"}, 32'(aw_ready), 32'd1);
        check_eq({tag, "_bvalid_dropped"}, 32'(b_valid), 32'd0);
    endtask

    task automatic burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] btype, input int early,
                         input logic [1:0] exp_resp, input string tag);
        aw_phase(addr, 8'(len), size, btype);
        w_phase(len, early);
        b_phase(exp_resp, 0, tag);
    endtask

    initial begin
        areset_n = 1'b0;
        aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_cache = 4'h3;
        aw_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0; dbg_addr = '0;

        // Reset state and release timing.
        repeat (3) tick();
        check_eq("rst_aw_ready", 32'(aw_ready), 32'd0);
        check_eq("rst_w_ready", 32'(w_ready), 32'd0);
        check_eq("rst_b_valid", 32'(b_valid), 32'd0);
        check_eq("rst_b_resp", 32'(b_resp), 32'd0);
        areset_n = 1'b1;
        check_eq("rel_aw_ready_pre", 32'(aw_ready), 32'd0);
        tick();
        check_eq("rel_aw_ready", 32'(aw_ready), 32'd1);

        // INCR at 0x10: words 4..7.
        fill(32'hA0);
        burst(32'h10, 3, 3'd2, 2'b01, -1, 2'b00, "incr");
        rd(4, 32'hA0, "incr_w4"); rd(5, 32'hA1, "incr_w5");
        rd(6, 32'hA2, "incr_w6"); rd(7, 32'hA3, "incr_w7");

        // WRAP at 0x08: beat order is words 2,3,0,1.
        fill(32'hB0);
        burst(32'h08, 3, 3'd2, 2'b10, -1, 2'b00, "wrap");
        rd(2, 32'hB0, "wrap_w2"); rd(3, 32'hB1, "wrap_w3");
        rd(0, 32'hB2, "wrap_w0"); rd(1, 32'hB3, "wrap_w1");

        // FIXED at 0x20: every beat lands on word 8.
        fill(32'h1);
        burst(32'h20, 2, 3'd2, 2'b00, -1, 2'b00, "fixed");
        rd(8, 32'h3, "fixed_w8");

        // FIXED again with a byte-0-only strobe on the last beat.
        fill(32'h1);
        beat_data[2] = 32'hFFFF_FF03;
        beat_strb[2] = 4'h1;
        burst(32'h20, 2, 3'd2, 2'b00, -1, 2'b00, "strb");
`ifdef AXI_SLAVE_WR_STRB_EN
        rd(8, 32'h0000_0003, "strb_w8");
`else
        rd(8, 32'hFFFF_FF03, "strb_w8");
`endif

        // Early w_last on beat 1: all beats accepted, SLVERR.
        fill(32'hD0);
        burst(32'h40, 3, 3'd2, 2'b01, 1, 2'b10, "early_last");
        rd(16, 32'hD0, "early_w16"); rd(19, 32'hD3, "early_w19");

        // Last word in range, second beat out of range.
        fill(32'hC0);
        burst(32'h3FC, 1, 3'd2, 2'b01, -1, 2'b11, "decerr");
        rd(255, 32'hC0, "decerr_w255"); rd(0, 32'hB2, "decerr_w0_kept");

        // Illegal requests: reserved burst, unaligned, oversize -- no writes.
        fill(32'hEE);
        burst(32'h40, 0, 3'd2, 2'b11, -1, 2'b10, "rsvd_burst");
        rd(16, 32'hD0, "rsvd_w16_kept");
        burst(32'h42, 0, 3'd2, 2'b01, -1, 2'b10, "unaligned");
        rd(16, 32'hD0, "unal_w16_kept");
        burst(32'h40, 0, 3'd3, 2'b01, -1, 2'b10, "oversize");
        rd(16, 32'hD0, "size_w16_kept");

        // WRAP with len=2 is SLVERR; also hold b_ready low for 5 cycles.
        fill(32'h55);
        aw_phase(32'h80, 8'd2, 3'd2, 2'b10);
        w_phase(2, -1);
        b_phase(2'b10, 5, "wrap_len_hold");

        // w_valid while IDLE is ignored.
        w_data = 32'h1234; w_valid = 1'b1; w_last = 1'b1;
        repeat (3) tick();
        check_eq("idle_w_ready", 32'(w_ready), 32'd0);
        check_eq("idle_b_valid", 32'(b_valid), 32'd0);
        check_eq("idle_aw_ready", 32'(aw_ready), 32'd1);
        w_valid = 1'b0; w_last = 1'b0;

        // Reset mid-DATA: first beat persists, no response.
        aw_phase(32'h60, 8'd3, 3'd2, 2'b01);
        w_data = 32'h77; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        areset_n = 1'b0;
        tick();
        check_eq("midrst_aw_ready", 32'(aw_ready), 32'd0);
        check_eq("midrst_w_ready", 32'(w_ready), 32'd0);
        check_eq("midrst_b_valid", 32'(b_valid), 32'd0);
        areset_n = 1'b1;
        tick();
        check_eq("midrst_aw_ready_rel", 32'(aw_ready), 32'd1);
        check_eq("midrst_b_valid_rel", 32'(b_valid), 32'd0);
        rd(24, 32'h77, "midrst_w24_kept");
        tick();
        check_eq("midrst_b_valid_later", 32'(b_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_slave_wr.md
AXI_SLAVE_WR -- requirements
Module: axi_slave_wr

Interface
REQ-001 SHALL take parameters: ADDR_BITS 32 (address width); DATA_BITS 32 (data width); LEN_BITS 8 (burst length width); SIZE_BITS 3 (size width); MEM_DEPTH 256 (internal memory depth in DATA_BITS words).
REQ-002 SHALL have ports: aclk in 1 (clock); areset_n in 1 (reset, synchronous, active-low); aw_addr in ADDR_BITS; aw_len in LEN_BITS; aw_size in SIZE_BITS; aw_burst in 2; aw_cache in 4 (ignored); aw_valid in 1; aw_ready out 1.
REQ-003 SHALL have ports: w_data in DATA_BITS; w_strb in DATA_BITS/8; w_last in 1; w_valid in 1; w_ready out 1; b_resp out 2; b_valid out 1; b_ready in 1.
REQ-004 SHALL have debug read ports: dbg_addr in log2(MEM_DEPTH) (word index); dbg_rdata out DATA_BITS (combinational read of memory at dbg_addr).

Function
REQ-005 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, with registered outputs: aw_ready=1 only in IDLE, w_ready=1 only in DATA, b_valid=1 only in RESP.
REQ-006 IDLE: on aw_valid&&aw_ready, SHALL capture addr/len/size/burst, clear beat counter and error flags, and enter DATA; w_ready rises the next cycle.
REQ-007 DATA: each w_valid&&w_ready beat SHALL write the word at the current address and increment the beat counter; the burst has aw_len+1 beats.
REQ-008 Address update per beat: FIXED(00) unchanged; INCR(01) +(1<<size); WRAP(10) +(1<<size), wrapping within an aligned window of (len+1)<<size bytes. Word index = addr >> log2(DATA_BITS/8).
REQ-009 Beat with counter==aw_len SHALL end DATA; b_valid rises the next cycle.
REQ-010 SLVERR flag SHALL set on any of: w_last != (counter==aw_len) on any beat; burst==11; size > log2(DATA_BITS/8); start address not aligned to size; WRAP with len not in {1,3,7,15}. Memory writes SHALL be suppressed for the whole burst when burst==11, size is illegal or address is unaligned.
REQ-011 DECERR flag SHALL set when any beat's word index >= MEM_DEPTH; that beat's write SHALL be suppressed.
REQ-012 RESP: b_resp = 11 if DECERR, else 10 if SLVERR, else 00; b_valid/b_resp SHALL hold stable until b_ready; on handshake, return to IDLE; aw_ready rises the next cycle.
REQ-013 Beat counter SHALL be LEN_BITS wide; aw_len=255 yields 256 beats with no counter overflow before termination.
REQ-014 aw_valid in DATA/RESP and w_valid in IDLE/RESP SHALL be ignored (no state change, no write).

Reset
REQ-015 While areset_n==0 at a clock edge: state=IDLE, aw_ready=0, w_ready=0, b_valid=0, b_resp=00, counter and flags cleared; aw_ready=1 on the first edge after release.
REQ-016 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be reset (already-written beats persist).

Configuration
REQ-017 Macro AXI_SLAVE_WR_STRB_EN: defined -> only bytes with w_strb[i]=1 are written; undefined -> w_strb ignored, full word written on every beat.

Structure
REQ-018 Shared package axi_pkg SHALL hold the width constants, burst encodings (FIXED/INCR/WRAP), response encodings (OKAY 00, SLVERR 10, DECERR 11) and the FSM state enum.
REQ-019 Sub-module axi_slave_wr_addr_gen SHALL compute the next address from addr/size/len/burst (combinational).

Verification
REQ-020 INCR: aw_addr=0x10, len=3, size=2, data 0xA0..0xA3, strb=F -> words 4..7 = A0..A3; b_resp=00.
REQ-021 WRAP: aw_addr=0x08, len=3, size=2 -> writes words 2,3,0,1 in order; b_resp=00.
REQ-022 FIXED: aw_addr=0x20, len=2, data 1,2,3 -> word 8 = 3; with STRB_EN and strb=0x1 on the last beat, data 0xFFFFFF03 leaves word 8 = 0x00000003.
REQ-023 Early w_last on beat 1 of len=3 -> all 4 beats accepted; b_resp=10.
REQ-024 aw_addr=0x3FC, len=1, INCR, size=2 -> word 255 written, beat 2 suppressed; b_resp=11.
REQ-025 b_ready held low 5 cycles -> b_valid/b_resp stable; aw_ready=0 until the cycle after the handshake; reset asserted mid-DATA -> aw_ready=1 one cycle after release, no b_valid.
